// File: rtl/ddr_sample_reader_pkg.sv
// Shared types and constants for the DDR sample playback reader.
package ddr_sample_reader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitCal,
    StFetch,
    StDrain,
    StDone
  } state_e;

  localparam logic [2:0]  CMD_READ   = 3'b001;
  localparam int unsigned ADDR_STEP  = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned WORD_W     = 256;

endpackage

// File: rtl/ddr_word_fifo.sv
// Small word FIFO between MIG read returns and the sample serializer.
// Depth must be a power of two; a push while full is accepted only alongside a pop.
module ddr_word_fifo
  import ddr_sample_reader_pkg::*;
#(
  parameter int unsigned Width = WORD_W,
  parameter int unsigned Depth = FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [Width-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [Width-1:0]         o_rd_data,
  output logic [$clog2(Depth):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FullCount);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_pop     = i_rd_en && !o_empty;
  assign w_push    = i_wr_en && (!o_full || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/ddr_sample_reader.sv
// Streams NUM_WORDS 256-bit words from MIG DDR and serializes them into 16-bit samples.
// Define READER_LOOP_EN to wrap the address back to BASE_ADDR and fetch forever.
module ddr_sample_reader
  import ddr_sample_reader_pkg::*;
#(
  parameter logic [28:0] BASE_ADDR = 29'd0,
  parameter int unsigned NUM_WORDS = 1024
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  input  logic                init_calib_complete,
  input  logic                start,
  input  logic                app_rdy,
  output logic                app_en,
  output logic [2:0]          app_cmd,
  output logic [28:0]         app_addr,
  input  logic [WORD_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  input  logic                sample_req,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  output logic                underrun,
  output logic                done
);

  state_e               r_state;
  state_e               w_state_next;
  logic [2:0]           r_outstanding;
  logic [15:0]          r_word_cnt;
  logic [3:0]           r_idx;
  logic [28:0]          r_addr;
  logic [SAMPLE_W-1:0]  r_sample;
  logic                 r_sample_valid;
  logic                 r_underrun;

  logic                 w_active;
  logic                 w_accept;
  logic                 w_beat;
  logic                 w_last_cmd;
  logic                 w_restart;
  logic                 w_credit;
  logic                 w_req_ok;
  logic                 w_take;
  logic                 w_pop;
  logic                 w_fifo_wr;
  logic [WORD_W-1:0]    w_fifo_rdata;
  logic [2:0]           w_fifo_count;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;

  assign w_active   = (r_state == StFetch) || (r_state == StDrain);
  assign w_accept   = app_en && app_rdy;
  // Beats with nothing outstanding belong to reads abandoned by a reset.
  assign w_beat     = app_rd_data_valid && w_active && (r_outstanding != 3'd0);
  assign w_last_cmd = (r_word_cnt == 16'(NUM_WORDS - 1));
  assign w_restart  = start && ((r_state == StIdle) || (r_state == StDone));
  assign w_credit   = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < 4'(FIFO_DEPTH);
  assign w_req_ok   = sample_req && w_active;
  assign w_take     = w_req_ok && !w_fifo_empty;
  assign w_pop      = w_take && (r_idx == 4'd15);
  assign w_fifo_wr  = w_beat && (!w_fifo_full || w_pop);

  ddr_word_fifo #(
    .Width (WORD_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (ui_clk),
    .i_rst     (ui_clk_sync_rst),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (app_rd_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_rdata),
    .o_count   (w_fifo_count),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) r_state <= StIdle;
    else                 r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (start) w_state_next = StWaitCal;
      StWaitCal: if (init_calib_complete) w_state_next = StFetch;
      StFetch: begin
`ifndef READER_LOOP_EN
        if (w_accept && w_last_cmd) w_state_next = StDrain;
`endif
      end
      StDrain:   if (r_outstanding == 3'd0 && w_fifo_empty) w_state_next = StDone;
      StDone:    if (start) w_state_next = StWaitCal;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    app_en       = (r_state == StFetch) && w_credit;
    app_cmd      = CMD_READ;
    app_addr     = r_addr;
    done         = (r_state == StDone);
    sample_data  = r_sample;
    sample_valid = r_sample_valid;
    underrun     = r_underrun;
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      r_addr         <= BASE_ADDR;
      r_word_cnt     <= '0;
      r_outstanding  <= '0;
      r_idx          <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      if (w_restart) begin
        r_addr     <= BASE_ADDR;
        r_word_cnt <= '0;
      end else if (w_accept) begin
`ifdef READER_LOOP_EN
        if (w_last_cmd) begin
          r_addr     <= BASE_ADDR;
          r_word_cnt <= '0;
        end else begin
          r_addr     <= r_addr + 29'(ADDR_STEP);
          r_word_cnt <= r_word_cnt + 16'd1;
        end
`else
        r_addr     <= r_addr + 29'(ADDR_STEP);
        r_word_cnt <= r_word_cnt + 16'd1;
`endif
      end

      if (w_restart) r_outstanding <= '0;
      else if (w_accept && !w_beat) r_outstanding <= r_outstanding + 3'd1;
      else if (!w_accept && w_beat) r_outstanding <= r_outstanding - 3'd1;

      r_sample_valid <= w_take;
      r_underrun     <= w_req_ok && w_fifo_empty;
      if (w_restart) begin
        r_idx <= '0;
      end else if (w_take) begin
        r_sample <= w_fifo_rdata[{r_idx, 4'b0000} +: SAMPLE_W];
        r_idx    <= r_idx + 4'd1;
      end else if (w_req_ok) begin
        r_sample <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_sample_reader.sv
// Self-checking bench for ddr_sample_reader with behavioural MIG read models.
module tb_ddr_sample_reader;

`ifdef READER_LOOP_EN
  localparam int BWords = 3;
`else
  localparam int BWords = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // Instance A: two-word playback, always-ready zero-latency memory.
  logic a_cal = 1'b1, a_start = 1'b0, a_rdy = 1'b1, a_req = 1'b0;
  logic a_en, a_under, a_svalid, a_done;
  logic [2:0] a_cmd;
  logic [28:0] a_addr;
  logic [255:0] a_rdata = '0;
  logic a_rvalid = 1'b0;
  logic [15:0] a_sdata;
  logic [28:0] a_cmds[$];
  logic [28:0] a_pend[$];

  // Instance B: controllable memory for stall, credit and reset scenarios.
  logic b_cal = 1'b1, b_start = 1'b0, b_rdy = 1'b1, b_req = 1'b0;
  logic b_en, b_under, b_svalid, b_done;
  logic [2:0] b_cmd;
  logic [28:0] b_addr;
  logic [255:0] b_rdata = '0;
  logic b_rvalid = 1'b0;
  logic [15:0] b_sdata;
  logic [28:0] b_cmds[$];
  logic [28:0] b_pend[$];
  logic b_mig_on = 1'b0;
  logic b_corrupt = 1'b0;

  ddr_sample_reader #(.BASE_ADDR(29'd0), .NUM_WORDS(2)) u_a (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .init_calib_complete(a_cal), .start(a_start),
    .app_rdy(a_rdy), .app_en(a_en), .app_cmd(a_cmd), .app_addr(a_addr),
    .app_rd_data(a_rdata), .app_rd_data_valid(a_rvalid), .sample_req(a_req),
    .sample_data(a_sdata), .sample_valid(a_svalid), .underrun(a_under), .done(a_done)
  );

  ddr_sample_reader #(.BASE_ADDR(29'd0), .NUM_WORDS(BWords)) u_b (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .init_calib_complete(b_cal), .start(b_start),
    .app_rdy(b_rdy), .app_en(b_en), .app_cmd(b_cmd), .app_addr(b_addr),
    .app_rd_data(b_rdata), .app_rd_data_valid(b_rvalid), .sample_req(b_req),
    .sample_data(b_sdata), .sample_valid(b_svalid), .underrun(b_under), .done(b_done)
  );

  // Word at address a holds samples (a/8)*16+1 .. (a/8)*16+16, ascending.
  function automatic logic [255:0] word_of(input logic [28:0] addr);
    logic [255:0] w;
    for (int k = 0; k < 16; k++) w[16*k +: 16] = 16'(32'(addr >> 3) * 16 + k + 1);
    return w;
  endfunction

  function automatic logic [28:0] exp_addr(input int i);
`ifdef READER_LOOP_EN
    return 29'((i % BWords) * 8);
`else
    return 29'(i * 8);
`endif
  endfunction

  always @(posedge clk) begin
    if (a_en && a_rdy) begin
      a_cmds.push_back(a_addr);
      a_pend.push_back(a_addr);
    end
    if (a_pend.size() > 0) begin
      a_rvalid <= 1'b1;
      a_rdata  <= word_of(a_pend.pop_front());
    end else begin
      a_rvalid <= 1'b0;
    end
  end

  // Pending reads survive DUT reset so abandoned beats can be replayed afterwards.
  always @(posedge clk) begin
    if (b_en && b_rdy) begin
      b_cmds.push_back(b_addr);
      b_pend.push_back(b_addr);
    end
    if (b_mig_on && b_pend.size() > 0) begin
      b_rvalid <= 1'b1;
      b_rdata  <= b_corrupt ? ~word_of(b_pend.pop_front()) : word_of(b_pend.pop_front());
    end else begin
      b_rvalid <= 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_start = 0; a_req = 0; a_cal = 1; a_rdy = 1;
    b_start = 0; b_req = 0; b_cal = 1; b_rdy = 1; b_mig_on = 0; b_corrupt = 0;
    tick(2);
    a_cmds.delete(); a_pend.delete(); b_cmds.delete(); b_pend.delete(); exp_q.delete();
    rst = 1'b0;
    tick(1);
  endtask

  task automatic b_pulse_start();
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
  endtask

  // One sample request on B; the value is scoreboarded and checked one cycle later.
  task automatic b_sample(input logic [15:0] exp, input string tag);
    logic [15:0] want;
    b_req = 1'b1;
    exp_q.push_back(exp);
    tick(1);
    b_req = 1'b0;
    want = exp_q.pop_front();
    n_vec++;
    if (b_svalid !== 1'b1 || b_sdata !== want) begin
      n_err++;
      $display("FAIL %s: valid=%b data=%h, required valid=1 data=%h", tag, b_svalid, b_sdata, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({a_en, a_svalid, a_under, a_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: en/valid/under/done=%b required 0000",
               {a_en, a_svalid, a_under, a_done});
    end
    n_vec++;
    if (a_addr !== 29'd0) begin
      n_err++; $display("FAIL reset_addr: got %h required 0", a_addr);
    end
    n_vec++;
    if (a_sdata !== 16'h0000) begin
      n_err++; $display("FAIL reset_sample: got %h required 0", a_sdata);
    end
    n_vec++;
    if (a_cmd !== 3'b001 || b_cmd !== 3'b001) begin
      n_err++; $display("FAIL reset_cmd: got %b/%b required 001", a_cmd, b_cmd);
    end
    n_vec++;
    if (b_en !== 1'b0 || b_done !== 1'b0) begin
      n_err++; $display("FAIL reset_b: en=%b done=%b required 0 0", b_en, b_done);
    end
  endtask

  task automatic test_playback();
    logic [15:0] want;
    do_reset();
    a_start = 1'b1;
    tick(1);
    a_start = 1'b0;
    tick(20);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        n_vec++;
        if (a_done !== 1'b0) begin
          n_err++; $display("FAIL playback_early_done: got %b required 0", a_done);
        end
      end
      a_req = 1'b1;
      exp_q.push_back(16'(i + 1));
      tick(1);
      a_req = 1'b0;
      want = exp_q.pop_front();
      n_vec++;
      if (a_svalid !== 1'b1 || a_sdata !== want || a_under !== 1'b0) begin
        n_err++;
        $display("FAIL playback_sample%0d: valid=%b data=%h under=%b, required 1 %h 0",
                 i, a_svalid, a_sdata, a_under, want);
      end
      tick(3);
    end
    tick(5);
    n_vec++;
    if (a_done !== 1'b1) begin
      n_err++; $display("FAIL playback_done: got %b required 1", a_done);
    end
    n_vec++;
    if (a_cmds.size() != 2) begin
      n_err++; $display("FAIL playback_cmd_count: got %0d required 2", a_cmds.size());
    end else if (a_cmds[0] !== 29'd0 || a_cmds[1] !== 29'd8) begin
      n_err++; $display("FAIL playback_cmd_addr: got %h,%h required 0,8", a_cmds[0], a_cmds[1]);
    end
  endtask

  task automatic test_rdy_stall();
    int t;
    bit ok;
    do_reset();
    b_rdy = 1'b0;
    b_mig_on = 1'b1;
    b_pulse_start();
    t = 0;
    while (b_en !== 1'b1 && t < 20) begin
      tick(1);
      t++;
    end
    n_vec++;
    if (b_en !== 1'b1) begin
      n_err++; $display("FAIL stall_en_timeout: en=%b required 1", b_en);
    end
    ok = 1'b1;
    repeat (10) begin
      tick(1);
      if (b_en !== 1'b1 || b_addr !== exp_addr(0)) ok = 1'b0;
    end
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL stall_hold: en=%b addr=%h required 1 %h", b_en, b_addr, exp_addr(0));
    end
    b_rdy = 1'b1;
    tick(20);
    n_vec++;
    if (b_cmds.size() != 4) begin
      n_err++; $display("FAIL stall_cmd_count: got %0d required 4", b_cmds.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (b_cmds[i] !== exp_addr(i)) begin
          n_err++; $display("FAIL stall_addr%0d: got %h required %h", i, b_cmds[i], exp_addr(i));
        end
      end
    end
  endtask

  task automatic test_credit();
    do_reset();
    b_pulse_start();
    tick(30);
    n_vec++;
    if (b_cmds.size() != 4 || b_en !== 1'b0) begin
      n_err++; $display("FAIL credit_limit: cmds=%0d en=%b required 4 0", b_cmds.size(), b_en);
    end
    b_req = 1'b1;
    tick(1);
    b_req = 1'b0;
    n_vec++;
    if (b_under !== 1'b1 || b_sdata !== 16'h0000 || b_svalid !== 1'b0) begin
      n_err++;
      $display("FAIL credit_underrun: under=%b data=%h valid=%b required 1 0000 0",
               b_under, b_sdata, b_svalid);
    end
    tick(1);
    n_vec++;
    if (b_under !== 1'b0) begin
      n_err++; $display("FAIL credit_underrun_pulse: got %b required 0", b_under);
    end
    b_mig_on = 1'b1;
    tick(10);
    n_vec++;
    if (b_cmds.size() != 4) begin
      n_err++; $display("FAIL credit_full_fifo: cmds=%0d required 4", b_cmds.size());
    end
    b_sample(16'h0001, "credit_first_sample");
  endtask

  task automatic test_calib();
    int t;
    bit ok;
    do_reset();
    b_cal = 1'b0;
    b_mig_on = 1'b1;
    b_pulse_start();
    ok = 1'b1;
    repeat (100) begin
      tick(1);
      if (b_en !== 1'b0) ok = 1'b0;
    end
    n_vec++;
    if (!ok || b_cmds.size() != 0) begin
      n_err++; $display("FAIL calib_hold: en seen=%b cmds=%0d required 0 0", !ok, b_cmds.size());
    end
    b_cal = 1'b1;
    t = 0;
    while (b_cmds.size() == 0 && t < 5) begin
      tick(1);
      t++;
    end
    n_vec++;
    if (b_cmds.size() == 0) begin
      n_err++; $display("FAIL calib_release: cmds=0 required at least 1");
    end else if (b_cmds[0] !== 29'd0) begin
      n_err++; $display("FAIL calib_release: first addr %h required 0", b_cmds[0]);
    end
  endtask

  task automatic test_reset_midflight();
    int t;
    do_reset();
    b_pulse_start();
    t = 0;
    while (b_cmds.size() < 3 && t < 30) begin
      tick(1);
      t++;
    end
    b_rdy = 1'b0;
    n_vec++;
    if (b_cmds.size() != 3) begin
      n_err++; $display("FAIL midflight_outstanding: cmds=%0d required 3", b_cmds.size());
    end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    b_rdy = 1'b1;
    b_cmds.delete();
    // Replay the abandoned beats, marked, while the DUT sits in IDLE.
    b_corrupt = 1'b1;
    b_mig_on = 1'b1;
    tick(6);
    b_corrupt = 1'b0;
    b_pulse_start();
    tick(15);
    n_vec++;
    if (b_cmds.size() == 0 || b_cmds[0] !== 29'd0) begin
      n_err++; $display("FAIL midflight_restart_addr: cmds=%0d required first addr 0", b_cmds.size());
    end
    b_sample(16'h0001, "midflight_sample0");
    b_sample(16'h0002, "midflight_sample1");
  endtask

  task automatic test_loop();
    do_reset();
    b_mig_on = 1'b1;
    b_pulse_start();
    tick(20);
    for (int k = 0; k < 16; k++) begin
      b_sample(16'(k + 1), "loop_sample");
      tick(1);
    end
    tick(5);
    n_vec++;
    if (b_cmds.size() < 5) begin
      n_err++; $display("FAIL loop_cmd_count: got %0d required at least 5", b_cmds.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_vec++;
        if (b_cmds[i] !== exp_addr(i)) begin
          n_err++; $display("FAIL loop_addr%0d: got %h required %h", i, b_cmds[i], exp_addr(i));
        end
      end
    end
    n_vec++;
    if (b_done !== 1'b0) begin
      n_err++; $display("FAIL loop_done: got %b required 0", b_done);
    end
  endtask

  initial begin
    test_reset();
`ifndef READER_LOOP_EN
    test_playback();
`endif
    test_rdy_stall();
    test_credit();
    test_calib();
    test_reset_midflight();
`ifdef READER_LOOP_EN
    test_loop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
